// File: rtl/extram_arbiter_if.sv
// Bus bundle for extram_arbiter: Wishbone CPU port, VGA read port and SRAM pins.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface extram_arbiter_if #(
  parameter int unsigned ADR_WIDTH = 19
);
  logic [ADR_WIDTH-1:0] I_wb_adr;
  logic [7:0]           I_wb_dat;
  logic                 I_wb_stb;
  logic                 I_wb_we;
  logic                 O_wb_ack;
  logic [7:0]           O_wb_dat;
  logic                 I_vga_req;
  logic [ADR_WIDTH-1:0] I_vga_adr;
  logic [7:0]           O_vga_dat;
  logic [ADR_WIDTH-1:0] O_sram_adr;
  logic [7:0]           O_sram_dat;
  logic                 O_sram_dat_oe;
  logic [7:0]           I_sram_dat;
  logic                 O_sram_ce_n;
  logic                 O_sram_oe_n;
  logic                 O_sram_we_n;

  modport slave (
    input  I_wb_adr, I_wb_dat, I_wb_stb, I_wb_we, I_vga_req, I_vga_adr, I_sram_dat,
    output O_wb_ack, O_wb_dat, O_vga_dat, O_sram_adr, O_sram_dat, O_sram_dat_oe,
           O_sram_ce_n, O_sram_oe_n, O_sram_we_n
  );

  modport master (
    output I_wb_adr, I_wb_dat, I_wb_stb, I_wb_we, I_vga_req, I_vga_adr, I_sram_dat,
    input  O_wb_ack, O_wb_dat, O_vga_dat, O_sram_adr, O_sram_dat, O_sram_dat_oe,
           O_sram_ce_n, O_sram_oe_n, O_sram_we_n
  );
endinterface

// File: rtl/extram_arbiter.sv
// External async SRAM arbiter: fixed 1-cycle VGA reads always win; Wishbone CPU
// accesses fill idle cycles and are aborted and restarted when VGA needs the bus.
module extram_arbiter #(
  parameter int unsigned ADR_WIDTH = 19
) (
  input logic             I_clk,
  input logic             I_reset,
  extram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StVread, StWread, StWsetup, StWpulse} state_e;

  state_e                state_q, state_d;
  logic                  wb_ack_q, wb_ack_d;
  logic [7:0]            wb_dat_q, wb_dat_d;
  logic [7:0]            vga_dat_q, vga_dat_d;
  logic [ADR_WIDTH-1:0]  sram_adr_q, sram_adr_d;
  logic [7:0]            sram_dat_q, sram_dat_d;
  logic                  dat_oe_q, dat_oe_d;
  logic                  ce_n_q, ce_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;
  logic                  cpu_start;

  // ack_q blocks a second start while the master still holds stb on the ack cycle
  assign cpu_start = bus.I_wb_stb && !wb_ack_q && (state_q == StIdle || state_q == StVread);

  always_comb begin
    state_d    = state_q;
    wb_ack_d   = 1'b0;
    wb_dat_d   = wb_dat_q;
    vga_dat_d  = vga_dat_q;
    sram_adr_d = sram_adr_q;
    sram_dat_d = sram_dat_q;
    dat_oe_d   = 1'b0;
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;

    // A VGA read in flight always completes, even when the next one is queued behind it
    if (state_q == StVread) begin
      vga_dat_d = bus.I_sram_dat;
    end

    if (bus.I_vga_req) begin
      // Preempts any CPU cycle: the control defaults above drop we_n and the data driver
      state_d    = StVread;
      sram_adr_d = bus.I_vga_adr;
      ce_n_d     = 1'b0;
      oe_n_d     = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StVread: begin
          if (cpu_start && bus.I_wb_we) begin
            state_d    = StWsetup;
            sram_adr_d = bus.I_wb_adr;
            sram_dat_d = bus.I_wb_dat;
            dat_oe_d   = 1'b1;
            ce_n_d     = 1'b0;
          end else if (cpu_start) begin
            state_d    = StWread;
            sram_adr_d = bus.I_wb_adr;
            ce_n_d     = 1'b0;
            oe_n_d     = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
        StWread: begin
          wb_dat_d = bus.I_sram_dat;
          wb_ack_d = 1'b1;
          state_d  = StIdle;
        end
        StWsetup: begin
          state_d  = StWpulse;
          dat_oe_d = 1'b1;
          ce_n_d   = 1'b0;
          we_n_d   = 1'b0;
        end
        StWpulse: begin
          wb_ack_d = 1'b1;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q    <= StIdle;
      wb_ack_q   <= 1'b0;
      wb_dat_q   <= 8'h00;
      vga_dat_q  <= 8'h00;
      sram_adr_q <= '0;
      sram_dat_q <= 8'h00;
      dat_oe_q   <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      wb_ack_q   <= wb_ack_d;
      wb_dat_q   <= wb_dat_d;
      vga_dat_q  <= vga_dat_d;
      sram_adr_q <= sram_adr_d;
      sram_dat_q <= sram_dat_d;
      dat_oe_q   <= dat_oe_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
    end
  end

  assign bus.O_wb_ack      = wb_ack_q;
  assign bus.O_wb_dat      = wb_dat_q;
  assign bus.O_vga_dat     = vga_dat_q;
  assign bus.O_sram_adr    = sram_adr_q;
  assign bus.O_sram_dat    = sram_dat_q;
  assign bus.O_sram_dat_oe = dat_oe_q;
  assign bus.O_sram_ce_n   = ce_n_q;
  assign bus.O_sram_oe_n   = oe_n_q;
  assign bus.O_sram_we_n   = we_n_q;

endmodule
